// File: rtl/nrisc_ula_pkg.sv
// ---------------------------------------------------------------------------
// nrisc_ula_pkg
// Shared definitions for the NRISC ALU (ULA) issue/retire block:
//   - bit positions inside the {M,Z,C} flag vector
//   - op_cond encodings (condition under which an op executes)
//   - issue FSM state encoding
//   - ULA_ctrl command constants ([3:1] = operation, [0] = variant)
// ---------------------------------------------------------------------------
package nrisc_ula_pkg;

  // Flag vector layout, shared by ULA_flags and the architectural flags.
  localparam int FLG_M = 2;  // result negative (MSB set)
  localparam int FLG_Z = 1;  // result zero
  localparam int FLG_C = 0;  // carry / borrow

  localparam int FLAGS_W = 3;

  // Execution condition carried with every op.
  typedef enum logic [1:0] {
    COND_AL = 2'b00,  // always
    COND_Z  = 2'b01,  // only if Z set
    COND_C  = 2'b10,  // only if C set
    COND_M  = 2'b11   // only if M set
  } cond_e;

  // Issue/retire FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // waiting for an op
    ST_EXEC = 2'b01,  // ULA samples its registered inputs this cycle
    ST_CAPT = 2'b10,  // ULA result valid, captured at the end of this cycle
    ST_WB   = 2'b11   // result presented to the register file
  } state_e;

  // ULA_ctrl commands. The issue block passes op_ctrl through untouched;
  // these names exist so decode and the bench speak the same language.
  localparam logic [3:0] ULA_ADD  = 4'b0000;
  localparam logic [3:0] ULA_SUB  = 4'b0001;
  localparam logic [3:0] ULA_AND  = 4'b0010;
  localparam logic [3:0] ULA_OR   = 4'b0100;
  localparam logic [3:0] ULA_XOR  = 4'b0110;
  localparam logic [3:0] ULA_PASS = 4'b1110;

endpackage : nrisc_ula_pkg

// File: rtl/nrisc_ula_cond_eval.sv
// ---------------------------------------------------------------------------
// nrisc_ula_cond_eval
// Purely combinational condition check: decides whether an op with the given
// op_cond executes, based on the current architectural flags.
// Ports:
//   cond   in  2  op_cond encoding (see cond_e)
//   flags  in  3  architectural flags {M,Z,C}
//   take   out 1  1 = op executes, 0 = op is consumed without effect
// ---------------------------------------------------------------------------
module nrisc_ula_cond_eval
  import nrisc_ula_pkg::*;
(
  input  logic [1:0]         cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               take
);

  always_comb begin
    // NOTE: take gets a value before the case so that no path through the
    // block leaves it unassigned; otherwise a latch would be inferred.
    take = 1'b1;
    case (cond)
      COND_AL: take = 1'b1;
      COND_Z:  take = flags[FLG_Z];
      COND_C:  take = flags[FLG_C];
      COND_M:  take = flags[FLG_M];
      default: take = 1'b1;
    endcase
  end

endmodule : nrisc_ula_cond_eval

// File: rtl/nrisc_ula_issue.sv
// ---------------------------------------------------------------------------
// nrisc_ula_issue
// Issue/retire side of the NRISC ALU (ULA) interface. Takes one op per
// op_valid/op_ready handshake, drives registered ULA_A/ULA_B/ULA_ctrl, waits
// out the ULA's one-cycle registered latency, then captures ULA_OUT/ULA_flags
// into a write-back buffer and maintains the architectural flag register.
//
// Timeline of a taken op (edges are rising clk edges):
//   E0 accept   : ula_a/ula_b/ula_ctrl loaded, IDLE/WB -> EXEC
//   E1          : ULA registers its inputs,     EXEC -> CAPT
//   E2 capture  : wb_* and (optionally) flags_q loaded, CAPT -> WB
//   wb_valid is high after E2, i.e. two cycles after the accept edge.
//
// Parameters:
//   TAM   datapath width (must match the ULA)
//   REGW  destination register index width
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid/op_ready        op handshake from decode
//   op_ctrl/op_a/op_b        ULA command and operands
//   op_dst                   write-back register index
//   op_setf                  1 = op updates flags_q
//   op_cond                  execution condition against flags_q
//   ula_a/ula_b/ula_ctrl     registered ULA inputs
//   ula_out/ula_flags        ULA result and {minus,zero,carry}
//   wb_valid/wb_ready        write-back handshake to the register file
//   wb_data/wb_dst           write-back payload
//   flags_q                  architectural flags {M,Z,C}
// ---------------------------------------------------------------------------
module nrisc_ula_issue
  import nrisc_ula_pkg::*;
#(
  parameter int TAM  = 16,
  parameter int REGW = 4
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               op_valid,
  output logic               op_ready,
  input  logic [3:0]         op_ctrl,
  input  logic [TAM-1:0]     op_a,
  input  logic [TAM-1:0]     op_b,
  input  logic [REGW-1:0]    op_dst,
  input  logic               op_setf,
  input  logic [1:0]         op_cond,

  output logic [TAM-1:0]     ula_a,
  output logic [TAM-1:0]     ula_b,
  output logic [3:0]         ula_ctrl,
  input  logic [TAM-1:0]     ula_out,
  input  logic [FLAGS_W-1:0] ula_flags,

  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [TAM-1:0]     wb_data,
  output logic [REGW-1:0]    wb_dst,

  output logic [FLAGS_W-1:0] flags_q
);

  state_e          r_state;
  logic [REGW-1:0] r_dst;   // destination of the op currently in flight
  logic            r_setf;  // flag-update request of the op in flight

  logic            w_take;
  logic            w_accept;
  logic            w_issue;

  // Condition is checked against the architectural flags. Those are written
  // at the capture edge, which always precedes the next possible accept, so
  // no forwarding from ula_flags is needed.
  nrisc_ula_cond_eval u_cond_eval (
    .cond  (op_cond),
    .flags (flags_q),
    .take  (w_take)
  );

  // Accepting in WB is only allowed when the pending result retires on the
  // same edge, so the write-back buffer is never overwritten while held.
  assign op_ready = (r_state == ST_IDLE) || ((r_state == ST_WB) && wb_ready);
  assign w_accept = op_valid && op_ready;
  assign w_issue  = w_accept && w_take;

  // NOTE: every register below is updated with non-blocking assignments so
  // all of them see the pre-edge values of each other, as real flops do.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset clears the whole datapath including ula_* and wb_*,
      // so nothing stale is visible downstream after reset; r_dst/r_setf
      // are cleared too because there are only a handful of bits.
      r_state  <= ST_IDLE;
      r_dst    <= '0;
      r_setf   <= 1'b0;
      ula_a    <= '0;
      ula_b    <= '0;
      ula_ctrl <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_dst   <= '0;
      flags_q  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A false-condition op is consumed here and simply disappears.
          if (w_issue) begin
            ula_a    <= op_a;
            ula_b    <= op_b;
            ula_ctrl <= op_ctrl;
            r_dst    <= op_dst;
            r_setf   <= op_setf;
            r_state  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // ULA samples ula_* on this edge; its result appears one cycle later.
          r_state <= ST_CAPT;
        end

        ST_CAPT: begin
          wb_data  <= ula_out;
          wb_dst   <= r_dst;
          wb_valid <= 1'b1;
          if (r_setf) begin
            flags_q <= ula_flags;
          end
          r_state <= ST_WB;
        end

        ST_WB: begin
          // Result is held until the register file takes it. On the retire
          // edge a new op may be accepted; if its condition fails it is
          // dropped and the block idles.
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (w_issue) begin
              ula_a    <= op_a;
              ula_b    <= op_b;
              ula_ctrl <= op_ctrl;
              r_dst    <= op_dst;
              r_setf   <= op_setf;
              r_state  <= ST_EXEC;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : nrisc_ula_issue

// File: tb/tb_nrisc_ula_issue.sv
// ---------------------------------------------------------------------------
// tb_nrisc_ula_issue
// Bench for nrisc_ula_issue. Contains a behavioural ULA with one cycle of
// registered latency, a flag model and a scoreboard of expected write-backs.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_nrisc_ula_issue;
  import nrisc_ula_pkg::*;

  localparam int TAM  = 16;
  localparam int REGW = 4;

  logic               clk;
  logic               rst;
  logic               op_valid;
  logic               op_ready;
  logic [3:0]         op_ctrl;
  logic [TAM-1:0]     op_a;
  logic [TAM-1:0]     op_b;
  logic [REGW-1:0]    op_dst;
  logic               op_setf;
  logic [1:0]         op_cond;
  logic [TAM-1:0]     ula_a;
  logic [TAM-1:0]     ula_b;
  logic [3:0]         ula_ctrl;
  logic [TAM-1:0]     ula_out;
  logic [2:0]         ula_flags;
  logic               wb_valid;
  logic               wb_ready;
  logic [TAM-1:0]     wb_data;
  logic [REGW-1:0]    wb_dst;
  logic [2:0]         flags_q;

  typedef struct packed {
    logic [TAM-1:0]  data;
    logic [REGW-1:0] dst;
    logic [2:0]      flags;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] m_flags;    // model of flags_q
  logic [3:0] last_ctrl;  // ctrl of the last op that actually issued
  int         n_checks = 0;
  int         n_errors = 0;

  nrisc_ula_issue #(.TAM(TAM), .REGW(REGW)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_ctrl   (op_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_dst    (op_dst),
    .op_setf   (op_setf),
    .op_cond   (op_cond),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_ctrl  (ula_ctrl),
    .ula_out   (ula_out),
    .ula_flags (ula_flags),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_dst    (wb_dst),
    .flags_q   (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ULA: returns {minus,zero,carry, result}.
  function automatic logic [TAM+2:0] ula_ref(input logic [3:0] c,
                                             input logic [TAM-1:0] a,
                                             input logic [TAM-1:0] b);
    logic [TAM:0]   wide;
    logic [TAM-1:0] r;
    logic           cy;
    cy = 1'b0;
    case (c[3:1])
      3'd0: begin
        if (c[0]) wide = {1'b0, a} - {1'b0, b};
        else      wide = {1'b0, a} + {1'b0, b};
        r  = wide[TAM-1:0];
        cy = wide[TAM];
      end
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = ~a;
      default: r = a;
    endcase
    return {r[TAM-1], (r == '0), cy, r};
  endfunction

  function automatic logic cond_model(input logic [1:0] c, input logic [2:0] f);
    case (c)
      2'b00:   return 1'b1;
      2'b01:   return f[1];
      2'b10:   return f[0];
      default: return f[2];
    endcase
  endfunction

  // Behavioural ULA: registered, no reset.
  always @(posedge clk) {ula_flags, ula_out} <= ula_ref(ula_ctrl, ula_a, ula_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a result retires on the edge following a falling edge where
  // wb_valid and wb_ready are both high.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_data",  {16'b0, wb_data}, {16'b0, e.data});
        check("wb_dst",   {28'b0, wb_dst},  {28'b0, e.dst});
        check("flags_q",  {29'b0, flags_q}, {29'b0, e.flags});
      end
    end
  end

  // Present one op after the next rising edge and hold it until accepted.
  task automatic issue(input logic [3:0] ctrl, input logic [TAM-1:0] a,
                       input logic [TAM-1:0] b, input logic [REGW-1:0] dst,
                       input logic setf, input logic [1:0] cond, output logic took);
    logic [TAM+2:0] r;
    exp_t e;
    int waited;
    @(posedge clk); #1;
    op_ctrl = ctrl; op_a = a; op_b = b; op_dst = dst;
    op_setf = setf; op_cond = cond; op_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!op_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) begin
      check("accept_timeout", {31'b0, op_ready}, 32'd1);
      op_valid = 1'b0;
      took = 1'b0;
      return;
    end
    took = cond_model(cond, m_flags);
    if (took) begin
      r       = ula_ref(ctrl, a, b);
      e.data  = r[TAM-1:0];
      e.dst   = dst;
      e.flags = setf ? r[TAM+2:TAM] : m_flags;
      sb_q.push_back(e);
      m_flags   = e.flags;
      last_ctrl = ctrl;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // Called right after an accept edge: wb_valid must rise exactly 2 cycles later.
  task automatic lat_check();
    @(negedge clk); check("lat_e0", {31'b0, wb_valid}, 32'd0);
    @(negedge clk); check("lat_e1", {31'b0, wb_valid}, 32'd0);
    @(negedge clk); check("lat_e2", {31'b0, wb_valid}, 32'd1);
  endtask

  // Called after a skipped op: nothing may come out.
  task automatic no_wb_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(tag, {31'b0, wb_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic took;
    logic [TAM-1:0] held_data;
    rst = 1'b1; op_valid = 1'b0; op_ctrl = '0; op_a = '0; op_b = '0;
    op_dst = '0; op_setf = 1'b0; op_cond = 2'b00; wb_ready = 1'b1;
    m_flags = '0; last_ctrl = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_flags",    {29'b0, flags_q},  32'd0);
    check("rst_ula_ctrl", {28'b0, ula_ctrl}, 32'd0);
    check("rst_ula_a",    {16'b0, ula_a},    32'd0);
    check("rst_wb_data",  {16'b0, wb_data},  32'd0);
    check("rst_op_ready", {31'b0, op_ready}, 32'd1);

    // 1. ADD 3+4 with setf
    issue(ULA_ADD, 16'h0003, 16'h0004, 4'd1, 1'b1, 2'b00, took);
    lat_check();

    // 2. SUB 5-5 -> zero, flags 010
    issue(ULA_SUB, 16'h0005, 16'h0005, 4'd3, 1'b1, 2'b00, took);
    lat_check();

    // 4. cond=C with C=0: consumed, nothing issues
    issue(ULA_XOR, 16'h1234, 16'h00FF, 4'd7, 1'b1, 2'b10, took);
    check("skip_took", {31'b0, took}, 32'd0);
    check("skip_ula_ctrl", {28'b0, ula_ctrl}, {28'b0, last_ctrl});
    check("skip_op_ready", {31'b0, op_ready}, 32'd1);
    no_wb_check("skip_no_wb");

    // 3. cond=Z with Z=1: OR executes, flags unchanged
    issue(ULA_OR, 16'h00F0, 16'h000F, 4'd5, 1'b0, 2'b01, took);
    check("condz_took", {31'b0, took}, 32'd1);
    lat_check();

    // 5. Stall in WB for 5 cycles, then retire and accept on one edge
    @(posedge clk); #1 wb_ready = 1'b0;
    issue(ULA_ADD, 16'h8000, 16'h8001, 4'd9, 1'b1, 2'b00, took);
    lat_check();
    held_data = sb_q[0].data;
    op_ctrl = ULA_AND; op_a = 16'hF0F0; op_b = 16'h3C3C; op_dst = 4'd2;
    op_setf = 1'b1; op_cond = 2'b00; op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_op_ready", {31'b0, op_ready}, 32'd0);
      check("stall_wb_data",  {16'b0, wb_data},  {16'b0, held_data});
      check("stall_wb_dst",   {28'b0, wb_dst},   32'd9);
      check("stall_wb_valid", {31'b0, wb_valid}, 32'd1);
    end
    fork
      begin @(posedge clk); #1 wb_ready = 1'b1; end
      issue(ULA_AND, 16'hF0F0, 16'h3C3C, 4'd2, 1'b1, 2'b00, took);
    join
    check("b2b_ula_ctrl", {28'b0, ula_ctrl}, {28'b0, ULA_AND});
    lat_check();

    // Random ops, all condition codes and ctrl values
    for (int i = 0; i < 10; i++) begin
      issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), took);
      if (took) lat_check();
      else      no_wb_check("rand_skip_no_wb");
    end

    // 6. Reset while in EXEC: op is discarded
    issue(ULA_ADD, 16'hFFFF, 16'h0001, 4'd4, 1'b1, 2'b00, took);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb_q.delete();
    m_flags = '0;
    last_ctrl = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_exec_no_wb", {31'b0, wb_valid}, 32'd0);
      check("rst_exec_flags", {29'b0, flags_q},  32'd0);
    end
    issue(ULA_SUB, 16'h0002, 16'h0003, 4'd6, 1'b1, 2'b00, took);
    lat_check();

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_nrisc_ula_issue
